// File: rtl/trace_commit_fifo.sv
// Retirement trace buffer: queues committed-instruction records for a trace consumer
// and keeps a shadow copy of the architectural GPR file built from the same commit stream.
module trace_commit_fifo #(
  parameter int XLEN  = 64,
  parameter int NREG  = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       commit_valid,
  input  logic [XLEN-1:0]            commit_pc,
  input  logic [31:0]                commit_inst,
  input  logic                       commit_wen,
  input  logic [$clog2(NREG)-1:0]    commit_waddr,
  input  logic [XLEN-1:0]            commit_wdata,
  output logic                       commit_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [31:0]                out_inst,
  output logic                       out_wen,
  output logic [$clog2(NREG)-1:0]    out_waddr,
  output logic [XLEN-1:0]            out_wdata,
  output logic [NREG*XLEN-1:0]       gpr_flat,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [15:0]                drop_cnt
);

  localparam int AWF = $clog2(DEPTH);
  localparam int CW  = AWF + 1;

  logic [AWF-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AWF-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    overflow_q, overflow_d;
  logic [15:0]             drop_cnt_q, drop_cnt_d;
  logic                    push_s, pop_s, drop_s;

  logic [XLEN-1:0]         pc_mem    [DEPTH];
  logic [31:0]             inst_mem  [DEPTH];
  logic                    wen_mem   [DEPTH];
  logic [$clog2(NREG)-1:0] waddr_mem [DEPTH];
  logic [XLEN-1:0]         wdata_mem [DEPTH];
  logic [XLEN-1:0]         gpr_q     [NREG];

  // Handshake flags come only from registered occupancy, so no path from out_ready to commit_ready.
  assign commit_ready = (count_q != CW'(DEPTH));
  assign out_valid    = (count_q != {CW{1'b0}});
  assign push_s       = commit_valid & commit_ready;
  assign pop_s        = out_valid & out_ready;
  assign drop_s       = commit_valid & ~commit_ready;

  assign out_pc    = pc_mem[rd_ptr_q];
  assign out_inst  = inst_mem[rd_ptr_q];
  assign out_wen   = wen_mem[rd_ptr_q];
  assign out_waddr = waddr_mem[rd_ptr_q];
  assign out_wdata = wdata_mem[rd_ptr_q];
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

  for (genvar g = 0; g < NREG; g++) begin : g_flat
    assign gpr_flat[g*XLEN +: XLEN] = gpr_q[g];
  end

  // Next-state for pointers, occupancy and drop accounting; clear overrides everything.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (clear) begin
      wr_ptr_d   = {AWF{1'b0}};
      rd_ptr_d   = {AWF{1'b0}};
      count_d    = {CW{1'b0}};
      overflow_d = 1'b0;
      drop_cnt_d = 16'h0000;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + AWF'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + AWF'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (drop_s) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != 16'hFFFF) begin
          drop_cnt_d = drop_cnt_q + 16'd1;
        end else begin
          drop_cnt_d = drop_cnt_q;
        end
      end else begin
        overflow_d = overflow_q;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= {AWF{1'b0}};
      rd_ptr_q   <= {AWF{1'b0}};
      count_q    <= {CW{1'b0}};
      overflow_q <= 1'b0;
      drop_cnt_q <= 16'h0000;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Record storage is not reset; out_* are only meaningful while out_valid is high.
  always_ff @(posedge clock) begin
    if (push_s && !clear) begin
      pc_mem[wr_ptr_q]    <= commit_pc;
      inst_mem[wr_ptr_q]  <= commit_inst;
      wen_mem[wr_ptr_q]   <= commit_wen;
      waddr_mem[wr_ptr_q] <= commit_waddr;
      wdata_mem[wr_ptr_q] <= commit_wdata;
    end
  end

  // Shadow GPRs track every valid commit, including dropped ones and those seen during clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        gpr_q[i] <= {XLEN{1'b0}};
      end
    end else if (commit_valid && commit_wen && (commit_waddr != '0)) begin
      gpr_q[commit_waddr] <= commit_wdata;
    end
  end

endmodule

// File: doc/trace_commit_fifo.md
TRACE_COMMIT_FIFO -- requirements
Module: trace_commit_fifo

Interface
REQ-001 Parameter XLEN, default 64: register and PC width.
REQ-002 Parameter NREG, default 32: GPR count; must be a power of two; AW = log2(NREG).
REQ-003 Parameter DEPTH, default 8: FIFO entries; must be a power of two, at least 2; CW = log2(DEPTH)+1.
REQ-004 Port clock, in, 1: single clock; all state updates on its rising edge.
REQ-005 Port reset, in, 1: asynchronous, active-high reset.
REQ-006 Port clear, in, 1: synchronous flush.
REQ-007 Ports commit_valid in 1, commit_pc in XLEN, commit_inst in 32, commit_wen in 1, commit_waddr in AW, commit_wdata in XLEN: one retired instruction per cycle.
REQ-008 Port commit_ready, out, 1: FIFO can accept a record.
REQ-009 Ports out_valid out 1, out_ready in 1, out_pc out XLEN, out_inst out 32, out_wen out 1, out_waddr out AW, out_wdata out XLEN: drain side to the trace consumer.
REQ-010 Port gpr_flat, out, NREG*XLEN: shadow GPR file; register i occupies bits [i*XLEN+XLEN-1 : i*XLEN].
REQ-011 Port count, out, CW: current occupancy.
REQ-012 Port overflow, out, 1: sticky; set when a record is dropped.
REQ-013 Port drop_cnt, out, 16: count of dropped records.

Function
REQ-014 Push = commit_valid & commit_ready; pop = out_valid & out_ready; both are evaluated at the same rising edge.
REQ-015 commit_ready = (count < DEPTH); it depends only on registered state and has no combinational path from out_ready.
REQ-016 out_valid = (count != 0); out_* present the head entry directly from storage; when out_valid=0, out_* values are don't-care.
REQ-017 Latency: a record pushed in cycle N is visible on out_* in cycle N+1 at the earliest; there is no same-cycle fall-through.
REQ-018 Ordering is strict FIFO; read and write pointers are AW_F = log2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
REQ-019 Push and pop in the same cycle: count is unchanged and both pointers advance; allowed at any occupancy 1..DEPTH-1.
REQ-020 When full, a pop alone frees the slot; a commit presented in that same cycle is not accepted (commit_ready=0) and is dropped per REQ-021.
REQ-021 Drop condition is commit_valid & ~commit_ready: set overflow; increment drop_cnt, saturating at 0xFFFF; the record is discarded.
REQ-022 Shadow GPR update: on commit_valid & commit_wen & (commit_waddr != 0), gpr[commit_waddr] <= commit_wdata; this applies whether the record is pushed or dropped.
REQ-023 gpr[0] reads 0 at all times; writes to index 0 are ignored.
REQ-024 gpr_flat reflects shadow state registered at the edge; an update in cycle N is visible in cycle N+1.
REQ-025 clear=1 at an edge empties the FIFO: pointers and count go to 0, and overflow and drop_cnt go to 0.
REQ-026 clear overrides push, pop and drop accounting in the same cycle; the FIFO ignores the commit.
REQ-027 clear does not affect the shadow GPRs; the REQ-022 shadow update still occurs during clear.

Reset
REQ-028 reset=1 immediately forces count=0, out_valid=0, commit_ready=1, overflow=0, drop_cnt=0, all shadow GPRs=0 and both pointers=0, independent of clock.
REQ-029 FIFO storage contents need not be reset.
REQ-030 A reset asserted mid-operation discards all buffered records; the first edge after deassertion behaves as from the empty state.
REQ-031 No output may glitch to a non-reset value while reset=1.

Verification
REQ-032 Single record: push pc=0x80000000, inst=0x00500093, wen=1, waddr=1, wdata=5 with out_ready=0 -> next cycle out_valid=1, count=1, out_* match, gpr_flat reg1=5; then out_ready=1 -> the following cycle count=0.
REQ-033 Fill and wrap: push 8 records with out_ready=0 -> commit_ready=0 at count=8; then push and pop continuously for 20 records -> output order matches input order across pointer wrap, and count holds.
REQ-034 Overflow: with FIFO full, present 3 commits with wen=1, waddr=2, wdata=7,8,9 -> overflow=1, drop_cnt=3, gpr reg2=9, and FIFO contents unchanged.
REQ-035 x0 write: commit wen=1, waddr=0, wdata=0xDEAD -> gpr reg0 stays 0; record pushed with out_waddr=0, out_wdata=0xDEAD.
REQ-036 Clear versus push: with count=5 and drop_cnt=2, assert clear alongside commit_valid=1, waddr=3, wdata=0x11 -> next cycle count=0, overflow=0, drop_cnt=0, gpr reg3=0x11.
REQ-037 Async reset: assert reset between edges with count=4 -> out_valid=0, count=0 and gpr_flat=0 before the next edge.
